// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default widths, the config record seen by the register
// block, and the MMIO register map of the PWM block.
package pwm_pkg;

    localparam int PWM_CHANNELS = 4;
    localparam int PWM_CNT_W    = 32;
    localparam int PWM_PRE_W    = 16;

    // Byte offsets within the PWM register window; duty registers are contiguous.
    localparam logic [7:0] REG_PERIOD      = 8'h00;
    localparam logic [7:0] REG_PRESCALE    = 8'h04;
    localparam logic [7:0] REG_DUTY0       = 8'h08;
    localparam logic [7:0] REG_DUTY_STRIDE = 8'h04;
    localparam logic [7:0] REG_CTRL        = 8'h18;

    typedef struct packed {
        logic [PWM_CNT_W-1:0]    period;
        logic [PWM_PRE_W-1:0]    prescale;
        logic [PWM_CHANNELS-1:0] polarity;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_if.sv
// Config/status bundle between the PWM register block (master) and pwm_core (slave).
interface pwm_if import pwm_pkg::*; #(
    parameter int CHANNELS = PWM_CHANNELS,
    parameter int CNT_W    = PWM_CNT_W,
    parameter int PRE_W    = PWM_PRE_W
) ();

    logic                      enable_in;
    logic                      load_in;
    logic [CNT_W-1:0]          period_in;
    logic [PRE_W-1:0]          prescale_in;
    logic [CHANNELS*CNT_W-1:0] duty_in;
    logic [CHANNELS-1:0]       polarity_in;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_done_out;
    logic                      load_ack_out;
    logic [CNT_W-1:0]          cnt_out;

    modport master (
        output enable_in, load_in, period_in, prescale_in, duty_in, polarity_in,
        input  pwm_out, period_done_out, load_ack_out, cnt_out
    );

    modport slave (
        input  enable_in, load_in, period_in, prescale_in, duty_in, polarity_in,
        output pwm_out, period_done_out, load_ack_out, cnt_out
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM counter: tick every prescale+1 clocks, restartable via clear.
module pwm_prescaler import pwm_pkg::*; #(
    parameter int PRE_W = PWM_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) pre_cnt <= '0;
        else                      pre_cnt <= pre_cnt + PRE_W'(1);
    end

endmodule

// File: rtl/pwm_core.sv
// Edge-aligned multi-channel PWM engine with a shared counter and double-buffered
// config that only switches at a period boundary (or while idle/disabled).
module pwm_core import pwm_pkg::*; #(
    parameter int CHANNELS = PWM_CHANNELS,
    parameter int CNT_W    = PWM_CNT_W,
    parameter int PRE_W    = PWM_PRE_W
) (
    input  logic clk,
    input  logic rst,
    pwm_if.slave bus
);

    typedef struct packed {
        logic [CNT_W-1:0]                 period;
        logic [PRE_W-1:0]                 prescale;
        logic [CHANNELS-1:0][CNT_W-1:0]   duty;
        logic [CHANNELS-1:0]              polarity;
    } cfg_t;

    cfg_t                active, pending;
    logic                pend_vld;
    logic [CNT_W-1:0]    cnt;
    logic                pre_tick, tick, run, at_end, wrap, apply;
    logic [CHANNELS-1:0] raw;

    assign run    = bus.enable_in && (active.period != '0);
    assign tick   = run && pre_tick;
    assign at_end = (cnt == active.period - CNT_W'(1));
    assign wrap   = tick && at_end;
    // Only pending state from earlier cycles is eligible; a same-cycle load waits.
    assign apply  = pend_vld && (wrap || !bus.enable_in || (active.period == '0));

    pwm_prescaler #(.PRE_W(PRE_W)) u_pre (
        .clk      (clk),
        .rst      (rst),
        .clear    (apply || !run),
        .prescale (active.prescale),
        .tick     (pre_tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign raw[i] = run && (cnt < active.duty[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active              <= '0;
            pending             <= '0;
            pend_vld            <= 1'b0;
            cnt                 <= '0;
            bus.pwm_out         <= '0;
            bus.period_done_out <= 1'b0;
            bus.load_ack_out    <= 1'b0;
        end else begin
            if (bus.load_in) begin
                pending.period   <= bus.period_in;
                pending.prescale <= bus.prescale_in;
                pending.duty     <= bus.duty_in;
                pending.polarity <= bus.polarity_in;
                pend_vld         <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end

            if (apply) begin
                active <= pending;
                cnt    <= '0;
            end else if (!run) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= at_end ? '0 : cnt + CNT_W'(1);
            end

            bus.period_done_out <= wrap;
            bus.load_ack_out    <= apply;
            bus.pwm_out         <= raw ^ active.polarity;
        end
    end

    assign bus.cnt_out = cnt;

endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: config table, hand-written boundary sequences, and a
// randomized run against a cycle-level reference model.
module tb_pwm_core;
    import pwm_pkg::*;

    localparam int CH = 4;
    localparam int CW = 32;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_if #(.CHANNELS(CH), .CNT_W(CW), .PRE_W(PW)) bus ();

    pwm_core #(.CHANNELS(CH), .CNT_W(CW), .PRE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int per, input int pre, input int d0, input int d1,
                            input int d2, input int d3, input logic [3:0] pol);
        bus.period_in   = CW'(per);
        bus.prescale_in = PW'(pre);
        bus.duty_in     = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
        bus.polarity_in = pol;
        bus.load_in     = 1'b1;
        step();
        bus.load_in     = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int k = 0;
        while (bus.load_ack_out !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        chk({name, "_ack"}, int'(bus.load_ack_out), 1);
    endtask

    task automatic wait_cnt(input string name, input int v);
        int k = 0;
        while (int'(bus.cnt_out) != v && k < 200) begin
            step();
            k++;
        end
        chk({name, "_cnt_reached"}, int'(bus.cnt_out), v);
    endtask

    // Config vectors with hand-derived steady-state expectations:
    // hi[i] = clocks pwm_out[i] is 1 per period, clks = clocks per period.
    typedef struct packed {
        logic [7:0]      per;
        logic [7:0]      pre;
        logic [3:0][7:0] duty;
        logic [3:0]      pol;
        logic [7:0]      clks;
        logic [3:0][7:0] hi;
    } vec_t;

    vec_t tbl [5];

    // Reference model state (plain integers, updated once per clock).
    int m_cnt, m_pre, a_per, a_pre, p_per, p_pre;
    int a_duty [4];
    int p_duty [4];
    logic [3:0] a_pol, p_pol;
    bit pend;
    int r_per, r_pre;
    int r_duty [4];
    logic [3:0] r_pol;
    logic [3:0] e_pwm;
    bit e_done, e_ack;
    int e_cnt;

    task automatic model_step(input bit r, input bit en, input bit ld);
        bit running, tk, wr, ap;
        if (r) begin
            m_cnt = 0; m_pre = 0; a_per = 0; a_pre = 0; p_per = 0; p_pre = 0;
            a_pol = '0; p_pol = '0; pend = 0;
            for (int i = 0; i < 4; i++) begin a_duty[i] = 0; p_duty[i] = 0; end
            e_pwm = '0; e_done = 0; e_ack = 0; e_cnt = 0;
            return;
        end
        running = en && (a_per > 0);
        tk      = running && (m_pre == a_pre);
        wr      = tk && (m_cnt == a_per - 1);
        ap      = pend && (wr || !en || a_per == 0);
        for (int i = 0; i < 4; i++)
            e_pwm[i] = (running && m_cnt < a_duty[i]) ^ a_pol[i];
        e_done = wr;
        e_ack  = ap;
        if (ap) begin
            a_per = p_per; a_pre = p_pre; a_pol = p_pol;
            for (int i = 0; i < 4; i++) a_duty[i] = p_duty[i];
            m_cnt = 0; m_pre = 0;
        end else if (!running) begin
            m_cnt = 0; m_pre = 0;
        end else if (tk) begin
            m_cnt = (m_cnt + 1) % a_per;
            m_pre = 0;
        end else begin
            m_pre++;
        end
        if (ld) begin
            pend = 1; p_per = r_per; p_pre = r_pre; p_pol = r_pol;
            for (int i = 0; i < 4; i++) p_duty[i] = r_duty[i];
        end else if (ap) begin
            pend = 0;
        end
        e_cnt = m_cnt;
    endtask

    initial begin
        int hi [4];
        int dn, acks, pc, bad;
        bit en;

        tbl[0] = '{8'd10, 8'd0, {8'd15, 8'd10, 8'd3, 8'd0}, 4'b0000, 8'd10, {8'd10, 8'd10, 8'd3, 8'd0}};
        tbl[1] = '{8'd4,  8'd2, {8'd2,  8'd4,  8'd0, 8'd1}, 4'b0000, 8'd12, {8'd6,  8'd12, 8'd0, 8'd3}};
        tbl[2] = '{8'd6,  8'd0, {8'd6,  8'd0,  8'd5, 8'd2}, 4'b0010, 8'd6,  {8'd6,  8'd0,  8'd1, 8'd2}};
        tbl[3] = '{8'd1,  8'd1, {8'd0,  8'd1,  8'd0, 8'd1}, 4'b1000, 8'd2,  {8'd2,  8'd2,  8'd0, 8'd2}};
        tbl[4] = '{8'd3,  8'd3, {8'd0,  8'd1,  8'd2, 8'd3}, 4'b0101, 8'd12, {8'd0,  8'd8,  8'd8, 8'd0}};

        rst = 1'b1;
        bus.enable_in = 1'b0; bus.load_in = 1'b0; bus.period_in = '0;
        bus.prescale_in = '0; bus.duty_in = '0; bus.polarity_in = '0;
        step();
        step();
        chk("rst_pwm",  int'(bus.pwm_out), 0);
        chk("rst_done", int'(bus.period_done_out), 0);
        chk("rst_ack",  int'(bus.load_ack_out), 0);
        chk("rst_cnt",  int'(bus.cnt_out), 0);
        rst = 1'b0;

        // First load from idle: applied the cycle after the strobe.
        bus.enable_in = 1'b1;
        load_cfg(10, 0, 0, 3, 10, 15, 4'b0000);
        chk("first_ack_early", int'(bus.load_ack_out), 0);
        step();
        chk("first_ack", int'(bus.load_ack_out), 1);
        chk("first_cnt", int'(bus.cnt_out), 0);
        step();
        chk("first_ack_once", int'(bus.load_ack_out), 0);
        chk("first_cnt_step", int'(bus.cnt_out), 1);

        for (int v = 0; v < 5; v++) begin
            load_cfg(int'(tbl[v].per), int'(tbl[v].pre), int'(tbl[v].duty[0]), int'(tbl[v].duty[1]),
                     int'(tbl[v].duty[2]), int'(tbl[v].duty[3]), tbl[v].pol);
            wait_ack($sformatf("vec%0d", v));
            step();
            for (int i = 0; i < 4; i++) hi[i] = 0;
            dn = 0;
            for (int c = 0; c < int'(tbl[v].clks); c++) begin
                for (int i = 0; i < 4; i++) hi[i] += int'(bus.pwm_out[i]);
                dn += int'(bus.period_done_out);
                step();
            end
            for (int i = 0; i < 4; i++)
                chk($sformatf("vec%0d_hi_ch%0d", v, i), hi[i], int'(tbl[v].hi[i]));
            chk($sformatf("vec%0d_done", v), dn, 1);
        end

        // Mid-period load: old period finishes, ack and done coincide.
        load_cfg(10, 0, 0, 3, 10, 15, 4'b0000);
        wait_ack("mid_setup");
        wait_cnt("mid", 4);
        load_cfg(6, 0, 2, 3, 10, 15, 4'b0000);
        pc = -1;
        for (int k = 0; k < 50 && bus.load_ack_out !== 1'b1; k++) begin
            pc = int'(bus.cnt_out);
            step();
        end
        chk("mid_ack", int'(bus.load_ack_out), 1);
        chk("mid_done_with_ack", int'(bus.period_done_out), 1);
        chk("mid_last_old_cnt", pc, 9);
        chk("mid_cnt_restart", int'(bus.cnt_out), 0);
        step();
        hi[0] = 0; dn = 0;
        for (int c = 0; c < 6; c++) begin
            hi[0] += int'(bus.pwm_out[0]);
            dn += int'(bus.period_done_out);
            step();
        end
        chk("mid_new_hi_ch0", hi[0], 2);
        chk("mid_new_done", dn, 1);

        // Two loads in one period: one ack, last value wins.
        wait_cnt("dbl", 1);
        load_cfg(6, 0, 5, 3, 10, 15, 4'b0000);
        load_cfg(6, 0, 7, 3, 10, 15, 4'b0000);
        acks = 0;
        for (int c = 0; c < 14; c++) begin
            acks += int'(bus.load_ack_out);
            step();
        end
        chk("dbl_single_ack", acks, 1);
        hi[0] = 0;
        for (int c = 0; c < 6; c++) begin
            hi[0] += int'(bus.pwm_out[0]);
            step();
        end
        chk("dbl_hi_ch0", hi[0], 6);

        // Enable drop mid-period with an inverted channel.
        load_cfg(10, 0, 0, 3, 10, 15, 4'b0010);
        wait_ack("en");
        wait_cnt("en", 5);
        bus.enable_in = 1'b0;
        step();
        chk("en_off_pwm",  int'(bus.pwm_out), 2);
        chk("en_off_cnt",  int'(bus.cnt_out), 0);
        chk("en_off_done", int'(bus.period_done_out), 0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            bad += int'(bus.cnt_out != 0) + int'(bus.period_done_out) + int'(bus.pwm_out != 4'b0010);
        end
        chk("en_off_hold", bad, 0);
        bus.enable_in = 1'b1;
        step();
        chk("en_on_cnt", int'(bus.cnt_out), 1);
        chk("en_on_pwm", int'(bus.pwm_out), 12);

        // Reset with a pending load: pending is discarded, never acknowledged.
        wait_cnt("rstp", 6);
        load_cfg(5, 0, 1, 1, 1, 1, 4'b0000);
        chk("rstp_cnt7", int'(bus.cnt_out), 7);
        rst = 1'b1;
        step();
        chk("rstp_pwm",  int'(bus.pwm_out), 0);
        chk("rstp_done", int'(bus.period_done_out), 0);
        chk("rstp_ack",  int'(bus.load_ack_out), 0);
        chk("rstp_cnt",  int'(bus.cnt_out), 0);
        rst = 1'b0;
        acks = 0; bad = 0; dn = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            acks += int'(bus.load_ack_out);
            dn   += int'(bus.period_done_out);
            bad  += int'(bus.pwm_out != 0) + int'(bus.cnt_out != 0);
        end
        chk("rstp_no_ack", acks, 0);
        chk("rstp_no_done", dn, 0);
        chk("rstp_idle", bad, 0);

        // Randomized run against the reference model.
        en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, ld;
            r  = (cyc == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = !en;
            ld = ($urandom_range(0, 14) == 0);
            r_per = int'($urandom_range(0, 7));
            r_pre = int'($urandom_range(0, 2));
            for (int i = 0; i < 4; i++) r_duty[i] = int'($urandom_range(0, 9));
            r_pol = 4'($urandom_range(0, 15));
            rst = r;
            bus.enable_in   = en;
            bus.load_in     = ld;
            bus.period_in   = CW'(r_per);
            bus.prescale_in = PW'(r_pre);
            bus.duty_in     = {CW'(r_duty[3]), CW'(r_duty[2]), CW'(r_duty[1]), CW'(r_duty[0])};
            bus.polarity_in = r_pol;
            model_step(r, en, ld);
            step();
            chk("rnd_pwm",  int'(bus.pwm_out), int'(e_pwm));
            chk("rnd_done", int'(bus.period_done_out), int'(e_done));
            chk("rnd_ack",  int'(bus.load_ack_out), int'(e_ack));
            chk("rnd_cnt",  int'(bus.cnt_out), e_cnt);
        end
        rst = 1'b0;
        bus.load_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- PWM generation engine directly downstream of the memory-mapped PWM register block.
- Takes period, duty, prescale and polarity values written by software through the MMIO registers and drives CHANNELS edge-aligned PWM outputs from one shared counter.
- Double-buffered: new settings are staged on a load strobe and applied only at a period boundary, so outputs never glitch.
- Emits per-period and load-acknowledge pulses that the register block can latch as status bits.

Parameters:
CHANNELS, 4, number of PWM outputs sharing one period counter
CNT_W, 32, width of the period, duty and counter values (matches the 32-bit MMIO data path)
PRE_W, 16, width of the prescaler value

Ports:
clk  in  1  clock
rst  in  1  reset
enable_in  in  1  run/stop; low holds the counter at 0 and drives outputs to their inactive level
load_in  in  1  one-cycle strobe; captures all *_in config values into the pending shadow
period_in  in  CNT_W  counter ticks per PWM period; 0 = outputs held inactive
prescale_in  in  PRE_W  counter advances once every prescale_in+1 clocks
duty_in  in  CHANNELS*CNT_W  per-channel active ticks per period; channel i at [i*CNT_W +: CNT_W]
polarity_in  in  CHANNELS  per-channel invert; 1 = active-low output
pwm_out  out  CHANNELS  PWM outputs, registered
period_done_out  out  1  one-cycle pulse on counter wrap
load_ack_out  out  1  one-cycle pulse when pending config becomes active
cnt_out  out  CNT_W  current counter value, for readback

Behaviour:
- Reset: synchronous, active-high, via rst on clk.
  - All outputs reset to 0: pwm_out, period_done_out, load_ack_out, cnt_out.
  - Active and pending config reset to 0; pending flag cleared; prescaler counter cleared.
  - Reset mid-period aborts the period; no done or ack pulse is emitted.
- Prescaler: pre_cnt counts 0..active_prescale, then wraps. tick=1 in the cycle where pre_cnt==active_prescale. With prescale 0, tick is high every cycle.
- Counter, active when enable_in=1 and active_period!=0, updated on tick:
  - If cnt==active_period-1: cnt<=0 and period_done_out=1 the next cycle.
  - Otherwise cnt<=cnt+1.
  - active_period=1 gives cnt held at 0 with a done pulse on every tick.
- Load:
  - load_in=1 copies period/prescale/duty/polarity into the pending regs and sets pending=1.
  - A repeated load before apply overwrites the pending values; only one ack is issued.
- Apply condition: pending=1 AND one of:
  - (a) tick with cnt==active_period-1 (wrap boundary);
  - (b) enable_in=0;
  - (c) active_period==0.
- Apply action:
  - active<=pending, pending<=0, cnt<=0, pre_cnt<=0.
  - load_ack_out=1 for exactly one cycle, the cycle after apply.
  - On a wrap apply, period_done_out pulses in the same cycle as the ack.
- Load/apply ordering:
  - A load that coincides with an apply condition is not applied that cycle; the apply evaluates only pending state from earlier cycles.
  - Therefore the earliest apply after a load is the following cycle (when idle or disabled).
- Output, per channel i:
  - raw_i = enable_in && active_period!=0 && cnt < active_duty[i].
  - pwm_out[i] <= raw_i ^ active_polarity[i], registered.
  - Latency: one clock from the cnt value to pwm_out.
  - duty=0 gives constant inactive; duty>=period gives constant active (100%). No special-case logic beyond the compare.
- Width rules: compares are unsigned CNT_W; the counter never exceeds active_period-1, so it cannot overflow.
- Enable:
  - Falling enable_in: cnt and pre_cnt <= 0 next cycle; pwm_out goes to the inactive level (= polarity) next cycle; no done pulse.
  - Rising enable_in: counting resumes from cnt=0, pre_cnt=0.
- cnt_out is the registered cnt.

Decomposition:
- Shared package pwm_pkg holds:
  - default widths CNT_W=32 and PRE_W=16;
  - typedef pwm_cfg_t (period, prescale, polarity vector), shared with the register block;
  - MMIO offset constants for the period/prescale/duty/control registers.
- One sub-module, pwm_prescaler (pre_cnt, tick, clear input).
- Counter, shadow registers and compare logic stay in pwm_core.

Test Plan:
- Reset, then load period=10, prescale=0, duty={0,3,10,15}, pol=0, enable=1 -> after the first apply: ch0 always 0; ch1 high 3 of every 10 cycles; ch2 and ch3 always 1; period_done pulses every 10 cycles.
- prescale=2, period=4, duty[0]=1 -> pwm_out[0] high 3 clocks, low 9 clocks; period_done every 12 clocks; cnt_out steps every 3 clocks.
- Mid-period (cnt=4) load period=6, duty[0]=2 -> no output change until the current 10-tick period ends; at wrap, load_ack_out and period_done_out pulse together; the next period is 6 ticks with 2 high.
- Two loads (duty 5, then 7) within one period -> single load_ack_out at the boundary; duty 7 takes effect.
- polarity[1]=1, then enable_in dropped mid-period -> pwm_out[1]=1 and the other channels 0 next cycle; cnt_out=0; no done pulse. Re-enable restarts at cnt=0.
- rst asserted at cnt=7 with pending=1 -> all outputs 0 next cycle; no ack ever issued; period=0 keeps outputs 0 after release.
